branch_predictor: RTL and testbench



---
 rtl/branch_predictor_pkg.sv | 14 +
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor_sat_counter.sv | 18 +
 rtl/branch_predictor.sv | 119 +++++++++++
 tb/tb_branch_predictor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the BTB and for the CPU code that feeds it training data.
// Holds the RISC-V control-transfer opcodes and the weakly-taken counter start value.
package branch_predictor_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Value of a freshly allocated or reset counter: 2^(ctr_bits-1). For a 1-bit counter this is 1.
    function automatic int unsigned weak_taken(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX training and statistics signals between the CPU and the branch predictor.
// The master side is the CPU; the slave side is the predictor.
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lk_pc;
    logic            pred_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_is_jump;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;

    logic [31:0]     upd_count;
    logic [31:0]     mispred_count;

    modport master (
        output lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target,
        input  pred_hit, pred_taken, pred_target, upd_count, mispred_count
    );

    modport slave (
        input  lk_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target,
        output pred_hit, pred_taken, pred_target, upd_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for a W-bit saturating up/down counter; holds when neither or both are requested.
// The counter state lives with the caller.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != '1)
            nxt = cur + W'(1);
        else if (dec && !inc && cur != '0)
            nxt = cur - W'(1);
    end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry direction counters and mispredict statistics.
// Lookup is combinational off register arrays; training writes at the clock edge.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(weak_taken(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
        logic                jump;
    } btb_entry_t;

    btb_entry_t [ENTRIES-1:0] btb;

    logic [31:0] upd_cnt;
    logic [31:0] mis_cnt;

    // ---------------- lookup ----------------
    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    btb_entry_t       lk_e;
    logic             lk_hit;
    logic             lk_taken;

    assign lk_idx   = bp.lk_pc[IDX+1:2];
    assign lk_tag   = bp.lk_pc[XLEN-1:IDX+2];
    assign lk_e     = btb[lk_idx];
    assign lk_hit   = lk_e.valid && (lk_e.tag == lk_tag);
    assign lk_taken = lk_hit && (lk_e.jump || lk_e.ctr[CTR_BITS-1]);

    assign bp.pred_hit    = lk_hit;
    assign bp.pred_taken  = lk_taken;
    assign bp.pred_target = lk_taken ? lk_e.target : bp.lk_pc + XLEN'(4);

    // ---------------- training ----------------
    logic [IDX-1:0]      up_idx;
    logic [TAG_W-1:0]    up_tag;
    btb_entry_t          up_e;
    btb_entry_t          new_e;
    logic                up_hit;
    logic                wr_en;
    logic [CTR_BITS-1:0] ctr_nxt;
    logic                mispred;
    logic                unused_pc_bits;

    assign up_idx = bp.upd_pc[IDX+1:2];
    assign up_tag = bp.upd_pc[XLEN-1:IDX+2];
    assign up_e   = btb[up_idx];
    assign up_hit = up_e.valid && (up_e.tag == up_tag);
    assign unused_pc_bits = ^bp.upd_pc[1:0];

    sat_counter #(.W(CTR_BITS)) u_ctr (
        .cur (up_e.ctr),
        .inc (bp.upd_taken),
        .dec (!bp.upd_taken),
        .nxt (ctr_nxt)
    );

    always_comb begin
        new_e = up_e;
        wr_en = 1'b0;
        if (up_hit) begin
            wr_en      = 1'b1;
            new_e.ctr  = ctr_nxt;
            new_e.jump = bp.upd_is_jump;
            if (bp.upd_taken)
                new_e.target = bp.upd_target;
        end else if (bp.upd_taken) begin
            // Taken miss claims the slot, evicting any alias.
            wr_en        = 1'b1;
            new_e.valid  = 1'b1;
            new_e.tag    = up_tag;
            new_e.target = bp.upd_target;
            new_e.ctr    = CTR_INIT;
            new_e.jump   = bp.upd_is_jump;
        end
    end

    assign mispred = (bp.upd_pred_taken != bp.upd_taken) ||
                     (bp.upd_taken && (bp.upd_pred_target != bp.upd_target));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid  <= 1'b0;
                btb[i].tag    <= '0;
                btb[i].target <= '0;
                btb[i].ctr    <= CTR_INIT;
                btb[i].jump   <= 1'b0;
            end
            upd_cnt <= '0;
            mis_cnt <= '0;
        end else if (bp.upd_valid) begin
            if (wr_en)
                btb[up_idx] <= new_e;
            if (upd_cnt != '1)
                upd_cnt <= upd_cnt + 32'd1;
            if (mispred && mis_cnt != '1)
                mis_cnt <= mis_cnt + 32'd1;
        end
    end

    assign bp.upd_count     = upd_cnt;
    assign bp.mispred_count = mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed training scenarios plus random traffic,
// compared each cycle against a table-based reference of the BTB.
module tb_branch_predictor;
    localparam int XLEN     = 32;
    localparam int ENTRIES  = 64;
    localparam int CTR_BITS = 2;
    localparam int IDX      = $clog2(ENTRIES);
    localparam int CMAX     = (1 << CTR_BITS) - 1;
    localparam int CWEAK    = 1 << (CTR_BITS - 1);
    localparam longint SAT  = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN)) bp();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // reference: one table row per index, counters as plain integers
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_jmp   [ENTRIES];
    longint      m_upd, m_mis;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = CWEAK; m_jmp[i] = 0;
        end
        m_upd = 0; m_mis = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                                     output logic [31:0] tgt);
        int i;
        i   = int'((pc >> 2) % ENTRIES);
        hit = m_valid[i] && (m_tag[i] == (pc >> (IDX + 2)));
        tk  = hit && (m_jmp[i] || m_ctr[i] >= CWEAK);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void m_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                                    input bit jmp, input bit ptk, input logic [31:0] ptgt);
        int i;
        int unsigned t;
        i = int'((pc >> 2) % ENTRIES);
        t = pc >> (IDX + 2);
        if (m_upd < SAT) m_upd++;
        if ((ptk != tk || (tk && ptgt != tgt)) && m_mis < SAT) m_mis++;
        if (m_valid[i] && m_tag[i] == t) begin
            m_ctr[i] = tk ? ((m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX)
                          : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (tk) m_tgt[i] = tgt;
            m_jmp[i] = jmp;
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_ctr[i] = CWEAK; m_jmp[i] = jmp;
        end
    endfunction

    // One cycle: drive at negedge, check lookup/counters before the edge, then advance the model.
    task automatic cyc(input bit rst, input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                       input bit tk, input logic [31:0] tgt, input bit jmp, input bit ptk,
                       input logic [31:0] ptgt);
        bit eh, et;
        logic [31:0] etg;
        @(negedge clk);
        reset              = rst;
        bp.lk_pc           = lk;
        bp.upd_valid       = uv;
        bp.upd_pc          = upc;
        bp.upd_taken       = tk;
        bp.upd_target      = tgt;
        bp.upd_is_jump     = jmp;
        bp.upd_pred_taken  = ptk;
        bp.upd_pred_target = ptgt;
        #1;
        m_lookup(lk, eh, et, etg);
        chk("pred_hit", 32'(bp.pred_hit), 32'(eh));
        chk("pred_taken", 32'(bp.pred_taken), 32'(et));
        chk("pred_target", bp.pred_target, etg);
        chk("upd_count", bp.upd_count, m_upd[31:0]);
        chk("mispred_count", bp.mispred_count, m_mis[31:0]);
        @(posedge clk);
        if (rst) m_reset();
        else if (uv) m_train(upc, tk, tgt, jmp, ptk, ptgt);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(0, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Train using the reference's own prediction as the carried-down prediction.
    task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit jmp);
        bit h, ptk;
        logic [31:0] ptgt;
        m_lookup(pc, h, ptk, ptgt);
        cyc(0, 32'h0, 1, pc, tk, tgt, jmp, ptk, ptgt);
    endtask

    logic [31:0] pool [8];

    initial begin
        pool = '{32'h100, 32'h200, 32'h300, 32'h104, 32'h1100, 32'h2204, 32'h40, 32'h3FC};
        reset = 1'b1;
        bp.lk_pc = 0; bp.upd_valid = 0; bp.upd_pc = 0; bp.upd_taken = 0; bp.upd_target = 0;
        bp.upd_is_jump = 0; bp.upd_pred_taken = 0; bp.upd_pred_target = 0;
        repeat (2) @(posedge clk);
        m_reset();

        look(32'h100);                                   // reset state
        cyc(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h104);  // first alloc, mispredict
        look(32'h100);                                   // hit, taken, 0x80
        train(32'h100, 0, 0, 0);
        train(32'h100, 0, 0, 0);
        look(32'h100);                                   // ctr 0 -> not taken
        repeat (4) train(32'h100, 1, 32'h80, 0);
        train(32'h100, 0, 0, 0);
        look(32'h100);                                   // saturated then one down: taken
        cyc(0, 32'h200, 1, 32'h200, 1, 32'h40, 0, 0, 32'h204);  // alias evicts 0x100
        look(32'h100);
        look(32'h200);
        cyc(0, 32'h300, 1, 32'h300, 1, 32'h500, 1, 0, 32'h304);  // jal
        look(32'h300);
        cyc(0, 32'h300, 1, 32'h300, 1, 32'h500, 1, 1, 32'h504);  // right dir, wrong target
        look(32'h300);
        // same-cycle lookup and update of one index sees old contents
        cyc(0, 32'h200, 1, 32'h200, 0, 0, 0, 1, 32'h40);
        cyc(0, 32'h200, 1, 32'h200, 0, 0, 0, 1, 32'h40);
        look(32'h200);
        // reset wins over a simultaneous update
        cyc(1, 32'h300, 1, 32'h300, 1, 32'h700, 1, 0, 32'h304);
        look(32'h300);
        look(32'h200);

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, tgt;
            bit tk, h, ptk;
            logic [31:0] ptgt;
            pc  = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : ($urandom & 32'hFFFF_FFFC);
            tgt = pool[$urandom_range(0, 7)] + 32'h1000;
            tk  = $urandom_range(0, 2) != 0;
            m_lookup(pc, h, ptk, ptgt);
            if ($urandom_range(0, 1) == 0) begin
                ptk  = $urandom_range(0, 1) != 0;
                ptgt = tgt ^ ($urandom_range(0, 1) ? 32'h0 : 32'h10);
            end
            cyc($urandom_range(0, 59) == 0, pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
                $urandom_range(0, 3) != 0, pc, tk, tgt, $urandom_range(0, 4) == 0, ptk, ptgt);
        end

        // counters pushed near the top must stick at all-ones
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        force dut.upd_cnt = 32'hFFFF_FFFE;
        force dut.mis_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.upd_cnt;
        release dut.mis_cnt;
        m_upd = 64'hFFFF_FFFE;
        m_mis = 64'hFFFF_FFFE;
        repeat (3) cyc(0, 32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h104);
        look(32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
